// File: rtl/mmio_pkg.sv
// mmio_pkg: default MMIO addresses, status-word field positions and a clog2 helper
// Shared by the bridge, its interface and its output FIFO.
package mmio_pkg;
    localparam logic [31:0] OUT_ADDR_DEF  = 32'h1001_0024;
    localparam logic [31:0] IN_ADDR_DEF   = 32'h1001_0028;
    localparam logic [31:0] STAT_ADDR_DEF = 32'h1001_002C;
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_FLAG_LSB  = 16;
    function automatic int mmio_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/mmio_port_bridge_if.sv
// mmio_port_bridge_if: MEM-stage bus and PortOut stream between pipeline and bridge
// Pipeline side (master): drives Address, WriteData, MemWrite, MemRead, RAM_ReadData, out_ready.
// Bridge side (slave): drives RAM_MemWrite, RAM_MemRead, ReadData, Stall, PortOut, out_valid.
interface mmio_port_bridge_if #(parameter int DATA_WIDTH = 32);
    logic [31:0]           Address;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  MemWrite;
    logic                  MemRead;
    logic [DATA_WIDTH-1:0] RAM_ReadData;
    logic                  RAM_MemWrite;
    logic                  RAM_MemRead;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  Stall;
    logic [DATA_WIDTH-1:0] PortOut;
    logic                  out_valid;
    logic                  out_ready;
    modport master (
        output Address, WriteData, MemWrite, MemRead, RAM_ReadData, out_ready,
        input  RAM_MemWrite, RAM_MemRead, ReadData, Stall, PortOut, out_valid
    );
    modport slave (
        input  Address, WriteData, MemWrite, MemRead, RAM_ReadData, out_ready,
        output RAM_MemWrite, RAM_MemRead, ReadData, Stall, PortOut, out_valid
    );
endinterface

// File: rtl/mmio_sync_fifo.sv
// mmio_sync_fifo: synchronous FIFO feeding PortOut
// Ports: clk, reset (sync, active-high), push_i/din_i write side, pop_i read side,
// full_o/empty_o/count_o status, head_o = oldest entry or 0 when empty.
// Simultaneous push and pop on a full FIFO is legal: the pop frees the slot being written.
module mmio_sync_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               din_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [mmio_clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]               head_o
);
    localparam int AW = mmio_clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    always_comb begin
        rd_d  = pop_i ? rd_q + AW'(1) : rd_q;
        wr_d  = push_i ? wr_q + AW'(1) : wr_q;
        cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: head_o is forced to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_i && !reset) mem_q[wr_q] <= din_i;
    end
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];
endmodule

// File: rtl/mmio_port_bridge.sv
// mmio_port_bridge: MEM-stage bridge decoding word addresses to DataMemory RAM or MMIO ports
// Ports: clk, reset (sync, active-high), bus (mmio_port_bridge_if.slave: pipeline loads/stores,
// RAM strobes, ReadData, Stall, PortOut stream), PortIn (asynchronous external input).
// Stores to OUT_ADDR queue into a FIFO draining to PortOut; loads from IN_ADDR return the
// synchronized PortIn, loads from STAT_ADDR return flags/count/full/empty.
// Optional macro MMIO_EDGE_CAPTURE_EN adds rising-edge flags on PortIn, cleared by a STAT read.
module mmio_port_bridge
    import mmio_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          IN_WIDTH   = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] OUT_ADDR   = OUT_ADDR_DEF,
    parameter logic [31:0] IN_ADDR    = IN_ADDR_DEF,
    parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mmio_port_bridge_if.slave   bus,
    input  logic [IN_WIDTH-1:0] PortIn
);
    localparam int AW = mmio_clog2(FIFO_DEPTH);
    logic                  hit_out, hit_in, hit_stat, hit_io;
    logic                  push, pop, full, empty, stall;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] head;
    logic [IN_WIDTH-1:0]   sync1_q, sync2_q, flags;
    logic [31:0]           stat;
    logic                  unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, bus.Address[1:0]};
    always_comb begin
        hit_out  = bus.Address[31:2] == OUT_ADDR[31:2];
        hit_in   = bus.Address[31:2] == IN_ADDR[31:2];
        hit_stat = bus.Address[31:2] == STAT_ADDR[31:2];
        hit_io   = hit_out | hit_in | hit_stat;
        pop      = ~empty & bus.out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO only stalls without one.
        stall    = bus.MemWrite & hit_out & full & ~pop;
        push     = bus.MemWrite & hit_out & ~stall;
        stat     = '0;
        stat[STAT_FLAG_LSB +: 16] = 16'(flags);
        stat[STAT_CNT_LSB +: 8]   = 8'(count);
        stat[STAT_FULL_BIT]       = full;
        stat[STAT_EMPTY_BIT]      = empty;
    end
    mmio_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.WriteData),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .head_o  (head)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= PortIn;
            sync2_q <= sync1_q;
        end
    end
`ifdef MMIO_EDGE_CAPTURE_EN
    logic [IN_WIDTH-1:0] sync3_q, flag_q, flag_d;
    // Clear applies first so a rising edge in the clearing cycle is still captured.
    always_comb flag_d = (flag_q & ~{IN_WIDTH{bus.MemRead & hit_stat}}) | (sync2_q & ~sync3_q);
    always_ff @(posedge clk) begin
        if (reset) begin
            sync3_q <= '0;
            flag_q  <= '0;
        end else begin
            sync3_q <= sync2_q;
            flag_q  <= flag_d;
        end
    end
    assign flags = flag_q;
`else
    assign flags = '0;
`endif
    assign bus.RAM_MemWrite = bus.MemWrite & ~hit_io;
    assign bus.RAM_MemRead  = bus.MemRead & ~hit_io;
    assign bus.ReadData     = hit_in ? DATA_WIDTH'(sync2_q) : hit_stat ? DATA_WIDTH'(stat) : bus.RAM_ReadData;
    assign bus.Stall        = stall;
    assign bus.PortOut      = head;
    assign bus.out_valid    = ~empty;
endmodule
